// File: rtl/ysyx_22041412_ifu_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input
// and the decode-facing instruction handshake.
interface ysyx_22041412_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [1:0]  inst_fault;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch: in-order imem requests under a credit limit, response FIFO,
// redirect flush with drop counting, and bus-error / misalignment fault reporting.
module ysyx_22041412_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  ysyx_22041412_ifu_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] F_NONE = 2'b00, F_BUS = 2'b01, F_MIS = 2'b10;

  typedef enum logic {RUN, HALT} state_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [1:0]  fault;
  } ent_t;

  state_e        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d, live;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, push_idx;
  ent_t          mem_q [DEPTH];
  ent_t          push_ent;
  logic          push, pop, req_fire;
  logic [CW:0]   credit;

  assign live   = outst_q - drop_q;
  assign credit = {1'b0, count_q} + {1'b0, live};

  // Gated by rst_n so nothing is requested while reset is held.
  assign bus.imem_req_valid = rst_n & (state_q == RUN) & ~bus.redirect_valid &
                              (credit < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;

  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = bus.inst_valid ? mem_q[rd_q].inst  : '0;
  assign bus.inst_pc    = bus.inst_valid ? mem_q[rd_q].pc    : '0;
  assign bus.inst_fault = bus.inst_valid ? mem_q[rd_q].fault : '0;
  assign pop            = bus.inst_valid & bus.inst_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q + (req_fire ? 64'd4 : 64'd0);
    outst_d  = outst_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    drop_d   = drop_q;
    count_d  = count_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    push     = 1'b0;
    push_idx = wr_q;
    push_ent = '0;
    if (bus.redirect_valid) begin
      // Everything in flight is stale, including a same-cycle response.
      drop_d   = outst_d;
      count_d  = '0;
      rd_d     = '0;
      wr_d     = '0;
      push_idx = '0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        push           = 1'b1;
        push_ent.pc    = bus.redirect_pc;
        push_ent.fault = F_MIS;
        count_d        = CW'(1);
        wr_d           = AW'(1);
        state_d        = HALT;
      end else begin
        pc_d    = bus.redirect_pc;
        state_d = RUN;
      end
    end else begin
      if (bus.imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          // Oldest live request was issued live*4 bytes behind pc_q.
          push        = 1'b1;
          push_ent.pc = pc_q - (64'(live) << 2);
          if (bus.imem_rsp_err) begin
            push_ent.fault = F_BUS;
            state_d        = HALT;
            drop_d         = outst_d;
          end else begin
            push_ent.inst  = bus.imem_rsp_data;
            push_ent.fault = F_NONE;
          end
        end
      end
      if (pop)  rd_d = rd_q + AW'(1);
      if (push) wr_d = wr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[push_idx] <= push_ent;
  end
endmodule

// File: doc/ysyx_22041412_ifu.md
Name: ysyx_22041412_ifu

Overview:
- Instruction fetch stage. Sits directly upstream of the decode stage and supplies it with one 32-bit instruction per handshake.
- Owns the fetch PC and issues in-order requests to instruction memory. Responses are buffered in a small FIFO.
- Handles redirects from branch/jump resolution and flushes stale in-flight fetches.
- Reports fetch faults (bus error, misaligned target) alongside the instruction.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, fetch address after reset
DEPTH, 2, instruction FIFO depth; power of 2, >=2; also the max outstanding-plus-buffered credit

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  fetch address (word aligned)
imem_rsp_valid  in  1  response valid; responses return in request order, one per accepted request, no backpressure
imem_rsp_data  in  32  instruction word
imem_rsp_err  in  1  bus error for this response
redirect_valid  in  1  flush and refetch from redirect_pc
redirect_pc  in  64  new fetch target
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decode consumes head
inst  out  32  instruction to decode
inst_pc  out  64  PC of inst
inst_fault  out  2  00 none, 01 bus error, 10 misaligned

Behaviour:
- Internal state:
  - pc_q: next fetch address.
  - fifo: entries {inst, pc, fault}; count 0..DEPTH.
  - outst: accepted requests not yet responded.
  - drop: responses to discard, drop <= outst; live = outst - drop.
  - FSM state in {RUN, HALT}.
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, count=0, outst=0, drop=0, state=RUN.
  - All outputs 0: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
  - A reset mid-transaction abandons everything; memory must be reset together with this block.
- Request issue:
  - imem_req_valid = (state==RUN) & ~redirect_valid & (count + live < DEPTH).
  - imem_req_addr = pc_q.
  - On valid&ready: outst+1 and pc_q += 4 (64-bit wrap, no trap).
  - First request is presented in the first cycle after rst_n rises.
  - While valid & ~ready, the address stays stable unless a redirect occurs.
- Response:
  - On imem_rsp_valid: outst-1.
  - If drop>0: drop-1 and the response is discarded.
  - Otherwise push {imem_rsp_data, pc_q - 4*live, fault}. The PC is computed from pre-update values.
  - The credit rule guarantees a live response always has a free slot. Overflow is impossible; the bench asserts this.
- Output:
  - inst_valid = (count!=0); inst/inst_pc/inst_fault reflect the FIFO head.
  - Pop on inst_valid & inst_ready.
  - Latency is response cycle N -> inst_valid in cycle N+1 (no bypass).
  - Push and pop in the same cycle is allowed; count is unchanged.
- Bus error:
  - A live response with imem_rsp_err=1 is pushed with fault=01 and inst=32'h0.
  - State -> HALT; drop = outst after this response (younger fetches discarded).
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO flushed (count=0); any same-cycle pop or push is cancelled.
  - drop = outst after accounting for a same-cycle response; that response is itself discarded.
  - No request is issued in the redirect cycle.
  - If redirect_pc[1:0]!=0: push one entry {inst=0, pc=redirect_pc, fault=10} into the flushed FIFO; state=HALT.
  - Otherwise: pc_q=redirect_pc, state=RUN.
- HALT:
  - No requests; the FIFO still drains to decode; outstanding responses are consumed as drops.
  - Exit only on redirect.
- FIFO pointers wrap modulo DEPTH; empty/full are derived from count.

Test Plan:
1. Reset release, memory always ready, 1-cycle response returning 32'h00000013 -> requests at 80000000, 80000004, ...; inst_valid first high 2 cycles after the first request; inst_pc sequential.
2. inst_ready=0 for 10 cycles -> count reaches 2, imem_req_valid low, no overflow; release -> entries at 80000000, 80000004 delivered in order, fetch resumes at 80000008.
3. Two requests outstanding, redirect to 80001000 with a response in the same cycle -> both old responses discarded, FIFO empty, next request at 80001000, first delivered inst_pc=80001000.
4. Response to 80000004 with err=1 -> entry {pc=80000004, fault=01}; no further requests; later response dropped; redirect to 80000100 resumes fetch.
5. Redirect to 80000102 -> single entry {pc=80000102, fault=10}; no request issued until the next aligned redirect.
6. rst_n pulsed low mid-stream with 2 outstanding -> all outputs 0 immediately; after release, fetch restarts at RESET_PC.
